// File: rtl/cpu_bus_responder.sv
// Memory-bus target for the 6502 core: RAM, countdown timer and keyboard FIFO.
// Define CPU_BUS_RESPONDER_TIMER_EN to build the timer registers and irq.
module cpu_bus_responder #(
    parameter int          RAM_AW    = 15,
    parameter logic [15:0] IO_BASE   = 16'hD000,
    parameter int          KBD_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic [7:0]  i_data,
    input  logic        wren,
    output logic [7:0]  o_data,
    input  logic [7:0]  kbd_data,
    input  logic        kbd_valid,
    output logic        kbd_ready,
    output logic        irq
);
    localparam int PW = $clog2(KBD_DEPTH);
    localparam int OW = PW + 1;

    logic          is_ram;
    logic          is_io;
    logic [7:0]    offset;
    logic          io_wr;
    logic [RAM_AW-1:0] ram_idx;

    assign is_ram  = (32'(address) < (32'd1 << RAM_AW));
    assign is_io   = !is_ram && (address[15:8] == IO_BASE[15:8]);
    assign offset  = address[7:0];
    assign io_wr   = is_io && wren;
    assign ram_idx = address[RAM_AW-1:0];

    // RAM kept free of reset so it maps onto block memory; o_data is
    // muxed after the registers so the RAM read stays registered inside.
    logic [7:0] ram [0:(1 << RAM_AW) - 1];
    logic [7:0] ram_q;
    logic       sel_ram_q;
    logic [7:0] io_q;
    logic [7:0] io_rd;

    always_ff @(posedge clock) begin
        if (is_ram && wren)
            ram[ram_idx] <= i_data;
        ram_q <= wren ? i_data : ram[ram_idx];
    end

    // Keyboard FIFO
    logic [7:0]    fifo [KBD_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [OW-1:0] occ;
    logic          prev_kbd_rd;
    logic          empty;
    logic          full;
    logic          kbd_rd;
    logic          push;
    logic          pop;
    logic [7:0]    kbd_stat;

    assign empty     = (occ == '0);
    assign full      = (occ == OW'(KBD_DEPTH));
    assign kbd_ready = !full;
    assign kbd_rd    = is_io && !wren && (offset == 8'h04);
    assign push      = kbd_valid && !full;
    assign pop       = kbd_rd && !prev_kbd_rd && !empty;
    assign kbd_stat  = {1'b0, 5'(occ), full, !empty};

    always_ff @(posedge clock) begin
        if (push && !reset)
            fifo[wr_ptr] <= kbd_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            occ         <= '0;
            prev_kbd_rd <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            occ         <= occ + OW'(push) - OW'(pop);
            prev_kbd_rd <= kbd_rd;
        end
    end

`ifdef CPU_BUS_RESPONDER_TIMER_EN
    logic [15:0] reload, reload_n;
    logic [15:0] count, count_n;
    logic        t_en, t_en_n;
    logic        t_ar, t_ar_n;
    logic        t_ie, t_ie_n;
    logic        expired, expired_n;
    logic        irq_q;

    // Clear is applied before the tick so a same-cycle expiry wins;
    // CPU writes to count/enable are applied after the tick and win.
    always_comb begin
        reload_n  = reload;
        count_n   = count;
        t_en_n    = t_en;
        t_ar_n    = t_ar;
        t_ie_n    = t_ie;
        expired_n = expired;
        if (io_wr && offset == 8'h03 && i_data[0])
            expired_n = 1'b0;
        if (t_en) begin
            if (count == '0) begin
                expired_n = 1'b1;
                if (t_ar)
                    count_n = reload;
                else
                    t_en_n = 1'b0;
            end else begin
                count_n = count - 16'd1;
            end
        end
        if (io_wr) begin
            case (offset)
                8'h00: reload_n[7:0] = i_data;
                8'h01: begin
                    reload_n[15:8] = i_data;
                    count_n        = {i_data, reload[7:0]};
                end
                8'h02: begin
                    t_en_n = i_data[0];
                    t_ar_n = i_data[1];
                    t_ie_n = i_data[2];
                    if (i_data[0] && !t_en)
                        count_n = reload;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            reload  <= '0;
            count   <= '0;
            t_en    <= 1'b0;
            t_ar    <= 1'b0;
            t_ie    <= 1'b0;
            expired <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            reload  <= reload_n;
            count   <= count_n;
            t_en    <= t_en_n;
            t_ar    <= t_ar_n;
            t_ie    <= t_ie_n;
            expired <= expired_n;
            irq_q   <= expired_n & t_ie_n;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        io_rd = 8'h00;
        if (!is_ram) begin
            if (!is_io) begin
                io_rd = wren ? 8'h00 : 8'hFF;
            end else if (!wren) begin
                case (offset)
`ifdef CPU_BUS_RESPONDER_TIMER_EN
                    8'h00: io_rd = reload[7:0];
                    8'h01: io_rd = reload[15:8];
                    8'h02: io_rd = {5'b0, t_ie, t_ar, t_en};
                    8'h03: io_rd = {7'b0, expired};
`endif
                    8'h04: io_rd = empty ? 8'h00 : fifo[rd_ptr];
                    8'h05: io_rd = kbd_stat;
                    default: io_rd = 8'h00;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sel_ram_q <= 1'b0;
            io_q      <= '0;
        end else begin
            sel_ram_q <= is_ram;
            io_q      <= io_rd;
        end
    end

    assign o_data = sel_ram_q ? ram_q : io_q;

endmodule
